pwm_capture_monitor: RTL

Synthesizable, parametrised successor to the testbench-only PWM visual monitor. Measures period and high time per channel in clock cycles and flags stuck channels. Checks complementary channel pairs for shoot-through and dead-time violations. Sits beside the PWM peripheral in the SoC; software and testbenches read results through a registered per-channel read port.

---
 rtl/pwm_capture_monitor.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/pwm_capture_monitor.sv
// PWM capture monitor: per-channel period/high-time measurement, stuck detection,
// complementary-pair shoot-through and dead-time checks, registered per-channel readback.
module pwm_capture_monitor #(
  parameter int unsigned NUM_CH  = 8,
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned MIN_DT  = 50,
  parameter int unsigned TIMEOUT = 1000000,
  parameter int unsigned SEL_W   = $clog2(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     pwm_in,
  input  logic [SEL_W-1:0]      rd_sel,
  input  logic                  clr_flags,
  output logic [CNT_W-1:0]      rd_period,
  output logic [CNT_W-1:0]      rd_high,
  output logic                  rd_valid,
  output logic [NUM_CH-1:0]     stuck,
  output logic [NUM_CH-1:0]     stuck_level,
  output logic [NUM_CH/2-1:0]   shoot_through,
  output logic [NUM_CH/2-1:0]   dt_violation,
  output logic [31:0]           edge_count
);
  localparam int unsigned NUM_PAIR = NUM_CH / 2;
  localparam int unsigned GAP_W    = $clog2(MIN_DT + 1);
  localparam int unsigned POP_W    = $clog2(NUM_CH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_MAX    = GAP_W'(MIN_DT);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  logic [NUM_CH-1:0]   r_sync1, r_sync2, r_prev;
  logic [NUM_CH-1:0]   w_rise, w_fall, w_edge, w_timeout;
  state_e              r_state   [NUM_CH];
  state_e              w_state_d [NUM_CH];
  logic [CNT_W-1:0]    r_run_cnt  [NUM_CH];
  logic [CNT_W-1:0]    r_idle_cnt [NUM_CH];
  logic [CNT_W-1:0]    r_period   [NUM_CH];
  logic [CNT_W-1:0]    r_high     [NUM_CH];
  logic [NUM_CH-1:0]   r_valid, r_seen, r_stuck, r_stuck_level;

  logic [NUM_PAIR-1:0] w_both_low, w_pair_rise, w_pair_fall, w_shoot_set, w_dt_set;
  logic [NUM_PAIR-1:0] r_armed, r_shoot, r_dt;
  logic [GAP_W-1:0]    r_gap_cnt [NUM_PAIR];

  logic [POP_W-1:0]    w_pop;
  logic [32:0]         w_ec_sum;
  logic [31:0]         r_edge_count;
  logic [CNT_W-1:0]    r_rd_period, r_rd_high;
  logic                r_rd_valid;

  assign w_rise = r_sync2 & ~r_prev;
  assign w_fall = ~r_sync2 & r_prev;
  assign w_edge = r_sync2 ^ r_prev;

  always_comb begin
    w_timeout = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // An edge in the same cycle as the timeout keeps the channel alive.
      w_timeout[i] = ~w_edge[i] & ~r_stuck[i] & (r_idle_cnt[i] == IDLE_LIMIT);
      w_state_d[i] = r_state[i];
      unique case (r_state[i])
        StIdle:  if (w_rise[i]) w_state_d[i] = StRun;
        StRun:   if (w_timeout[i]) w_state_d[i] = StIdle;
        default: w_state_d[i] = StIdle;
      endcase
    end
  end

  always_comb begin
    w_both_low  = '0;
    w_pair_rise = '0;
    w_pair_fall = '0;
    w_shoot_set = '0;
    w_dt_set    = '0;
    for (int k = 0; k < NUM_PAIR; k++) begin
      w_both_low[k]  = ~r_sync2[2*k] & ~r_sync2[2*k+1];
      w_pair_rise[k] = w_rise[2*k] | w_rise[2*k+1];
      w_pair_fall[k] = w_fall[2*k] | w_fall[2*k+1];
      w_shoot_set[k] = r_sync2[2*k] & r_sync2[2*k+1];
      // Only armed after a fall left both low, so the first rise is never checked.
      w_dt_set[k]    = w_pair_rise[k] & r_armed[k] & (r_gap_cnt[k] < GAP_MAX);
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_pop = w_pop + POP_W'(w_edge[i]);
    end
    w_ec_sum = {1'b0, (clr_flags ? 32'd0 : r_edge_count)} + 33'(w_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1       <= '0;
      r_sync2       <= '0;
      r_prev        <= '0;
      r_valid       <= '0;
      r_seen        <= '0;
      r_stuck       <= '0;
      r_stuck_level <= '0;
      r_armed       <= '0;
      r_shoot       <= '0;
      r_dt          <= '0;
      r_edge_count  <= '0;
      r_rd_period   <= '0;
      r_rd_high     <= '0;
      r_rd_valid    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i]    <= StIdle;
        r_run_cnt[i]  <= '0;
        r_idle_cnt[i] <= '0;
        r_period[i]   <= '0;
        r_high[i]     <= '0;
      end
      for (int k = 0; k < NUM_PAIR; k++) begin
        r_gap_cnt[k] <= '0;
      end
    end else begin
      r_sync1 <= pwm_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;

      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i]   <= w_state_d[i];
        r_run_cnt[i] <= w_rise[i] ? '0 : sat_inc(r_run_cnt[i]);
        if (w_rise[i]) r_seen[i] <= 1'b1;
        if (w_rise[i] && (r_state[i] == StRun)) r_period[i] <= sat_inc(r_run_cnt[i]);
        if (w_fall[i] && r_seen[i]) r_high[i] <= sat_inc(r_run_cnt[i]);

        if (w_edge[i]) begin
          r_idle_cnt[i] <= '0;
        end else if (!r_stuck[i]) begin
          r_idle_cnt[i] <= r_idle_cnt[i] + CNT_W'(1);
        end

        if (w_edge[i]) begin
          r_stuck[i] <= 1'b0;
        end else if (w_timeout[i]) begin
          r_stuck[i]       <= 1'b1;
          r_stuck_level[i] <= r_sync2[i];
        end

        if (w_timeout[i]) begin
          r_valid[i] <= 1'b0;
        end else if (w_rise[i] && (r_state[i] == StRun)) begin
          r_valid[i] <= 1'b1;
        end
      end

      for (int k = 0; k < NUM_PAIR; k++) begin
        r_shoot[k] <= (r_shoot[k] & ~clr_flags) | w_shoot_set[k];
        r_dt[k]    <= (r_dt[k] & ~clr_flags) | w_dt_set[k];
        if (w_pair_rise[k]) begin
          r_armed[k] <= 1'b0;
        end else if (w_pair_fall[k] && w_both_low[k]) begin
          r_armed[k]   <= 1'b1;
          r_gap_cnt[k] <= GAP_W'(1);
        end else if (r_armed[k] && w_both_low[k] && (r_gap_cnt[k] != GAP_MAX)) begin
          r_gap_cnt[k] <= r_gap_cnt[k] + GAP_W'(1);
        end
      end

      r_edge_count <= w_ec_sum[32] ? '1 : w_ec_sum[31:0];
      r_rd_period  <= r_period[rd_sel];
      r_rd_high    <= r_high[rd_sel];
      r_rd_valid   <= r_valid[rd_sel];
    end
  end

  assign stuck         = r_stuck & ~w_edge;
  assign stuck_level   = r_stuck_level & stuck;
  assign shoot_through = r_shoot;
  assign dt_violation  = r_dt;
  assign edge_count    = r_edge_count;
  assign rd_period     = r_rd_period;
  assign rd_high       = r_rd_high;
  assign rd_valid      = r_rd_valid;

endmodule
